// File: rtl/timer_counter_if.sv
// Control and display bundle of the countdown timer: control inputs from the
// timer FSM (master side) and registered BCD display/status outputs (slave side).
interface timer_counter_if;
    logic       enableCounter;
    logic       forward;
    logic       resetTimer;
    logic       segDemand;
    logic       minDemand;
    logic [3:0] secUnits;
    logic [3:0] secTens;
    logic [3:0] minUnits;
    logic [3:0] minTens;
    logic       zero;
    logic       alarm;

    modport master (
        output enableCounter, forward, resetTimer, segDemand, minDemand,
        input  secUnits, secTens, minUnits, minTens, zero, alarm
    );

    modport slave (
        input  enableCounter, forward, resetTimer, segDemand, minDemand,
        output secUnits, secTens, minUnits, minTens, zero, alarm
    );
endinterface

// File: rtl/timer_counter.sv
// MM:SS countdown timer with edit mode and BCD display outputs.
// Optional expiry flag enabled by defining TIMER_ALARM_EN.
module timer_counter #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MIN_MAX       = 99
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    MIN_TOP    = 7'(MIN_MAX);

    logic [5:0]    r_sec;
    logic [6:0]    r_min;
    logic [PW-1:0] r_presc;
    logic          r_seg_d;
    logic          r_min_d;
    logic [3:0]    r_sec_units;
    logic [3:0]    r_sec_tens;
    logic [3:0]    r_min_units;
    logic [3:0]    r_min_tens;
    logic          r_zero;

    logic          w_seg_rise;
    logic          w_min_rise;
    logic          w_edit;
    logic          w_count;
    logic          w_tick;
    logic [5:0]    w_sec_next;
    logic [6:0]    w_min_next;
    logic [PW-1:0] w_presc_next;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        to_bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Next-time computation: resetTimer > edit > countdown > hold.
    always_comb begin
        w_seg_rise   = bus.segDemand & ~r_seg_d;
        w_min_rise   = bus.minDemand & ~r_min_d;
        w_edit       = bus.enableCounter & bus.forward;
        w_count      = bus.enableCounter & ~bus.forward;
        w_tick       = w_count & (r_presc == PRESC_LAST);
        w_sec_next   = r_sec;
        w_min_next   = r_min;
        w_presc_next = '0;
        if (bus.resetTimer) begin
            w_sec_next = 6'd0;
            w_min_next = 7'd0;
        end else if (w_edit) begin
            if (w_seg_rise) begin
                w_sec_next = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
            end else begin
                w_sec_next = r_sec;
            end
            if (w_min_rise) begin
                w_min_next = (r_min >= MIN_TOP) ? 7'd0 : r_min + 7'd1;
            end else begin
                w_min_next = r_min;
            end
        end else if (w_count) begin
            w_presc_next = w_tick ? '0 : r_presc + PW'(1);
            if (w_tick && (r_sec != 6'd0)) begin
                w_sec_next = r_sec - 6'd1;
            end else if (w_tick && (r_min != 7'd0)) begin
                w_sec_next = 6'd59;
                w_min_next = r_min - 7'd1;
            end else begin
                w_sec_next = r_sec;
            end
        end else begin
            w_presc_next = '0;
        end
    end

    // Binary state and its BCD/zero view are registered on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sec       <= 6'd0;
            r_min       <= 7'd0;
            r_presc     <= '0;
            r_seg_d     <= 1'b0;
            r_min_d     <= 1'b0;
            r_sec_units <= 4'd0;
            r_sec_tens  <= 4'd0;
            r_min_units <= 4'd0;
            r_min_tens  <= 4'd0;
            r_zero      <= 1'b1;
        end else begin
            r_sec                     <= w_sec_next;
            r_min                     <= w_min_next;
            r_presc                   <= w_presc_next;
            r_seg_d                   <= bus.segDemand;
            r_min_d                   <= bus.minDemand;
            {r_sec_tens, r_sec_units} <= to_bcd({1'b0, w_sec_next});
            {r_min_tens, r_min_units} <= to_bcd(w_min_next);
            r_zero                    <= (w_sec_next == 6'd0) && (w_min_next == 7'd0);
        end
    end

    assign bus.secUnits = r_sec_units;
    assign bus.secTens  = r_sec_tens;
    assign bus.minUnits = r_min_units;
    assign bus.minTens  = r_min_tens;
    assign bus.zero     = r_zero;

`ifdef TIMER_ALARM_EN
    logic r_alarm;
    logic w_alarm_next;

    // Expiry flag: set only when a countdown tick lands on 00:00.
    always_comb begin
        w_alarm_next = r_alarm;
        if (bus.resetTimer) begin
            w_alarm_next = 1'b0;
        end else if (w_edit && (w_seg_rise || w_min_rise)) begin
            w_alarm_next = 1'b0;
        end else if (w_tick && (r_sec == 6'd1) && (r_min == 7'd0)) begin
            w_alarm_next = 1'b1;
        end else begin
            w_alarm_next = r_alarm;
        end
    end

    // Alarm register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= w_alarm_next;
        end
    end

    assign bus.alarm = r_alarm;
`else
    assign bus.alarm = 1'b0;
`endif
endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a time-level reference model pushes the
// expected display for every clock edge; a monitor pops and compares.
module tb_timer_counter;
    localparam int TPS  = 4;
    localparam int MMAX = 99;
`ifdef TIMER_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    timer_counter_if bus();

    timer_counter #(.TICKS_PER_SEC(TPS), .MIN_MAX(MMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: minutes/seconds plus cycles spent in the current countdown run.
    int m_mm = 0;
    int m_ss = 0;
    int m_run = 0;
    bit m_alarm = 1'b0;
    bit m_pseg = 1'b0;
    bit m_pmin = 1'b0;
    logic [17:0] exp_q[$];

    function automatic logic [17:0] pack(input int mm, input int ss, input bit z, input bit al);
        pack = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), z, al};
    endfunction

    task automatic model(input bit rst, input bit en, input bit fwd, input bit rt,
                         input bit seg, input bit mn);
        bit sr, mr;
        int total;
        if (rst) begin
            m_mm = 0; m_ss = 0; m_run = 0; m_alarm = 1'b0; m_pseg = 1'b0; m_pmin = 1'b0;
        end else begin
            sr = seg && !m_pseg;
            mr = mn && !m_pmin;
            m_pseg = seg;
            m_pmin = mn;
            if (rt) begin
                m_mm = 0; m_ss = 0; m_run = 0; m_alarm = 1'b0;
            end else if (en && fwd) begin
                m_run = 0;
                if (sr) m_ss = (m_ss + 1) % 60;
                if (mr) m_mm = (m_mm + 1) % (MMAX + 1);
                if (sr || mr) m_alarm = 1'b0;
            end else if (en) begin
                m_run++;
                if (m_run % TPS == 0) begin
                    total = m_mm * 60 + m_ss;
                    if (total > 0) begin
                        total--;
                        if (total == 0) m_alarm = 1'b1;
                    end
                    m_mm = total / 60;
                    m_ss = total % 60;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back(pack(m_mm, m_ss, (m_mm == 0) && (m_ss == 0), ALARM_ON ? m_alarm : 1'b0));
    endtask

    task automatic step(input bit rst, input bit en, input bit fwd, input bit rt,
                        input bit seg, input bit mn);
        reset             = rst;
        bus.enableCounter = en;
        bus.forward       = fwd;
        bus.resetTimer    = rt;
        bus.segDemand     = seg;
        bus.minDemand     = mn;
        model(rst, en, fwd, rt, seg, mn);
        @(negedge clk);
    endtask

    task automatic seg_pulse();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic min_pulse();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit en, input bit fwd, input int n);
        repeat (n) step(1'b0, en, fwd, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [17:0] dut_view();
        dut_view = {bus.minTens, bus.minUnits, bus.secTens, bus.secUnits, bus.zero, bus.alarm};
    endfunction

    task automatic check_time(input string name, input int mm, input int ss,
                              input bit z, input bit al);
        logic [17:0] want;
        want = pack(mm, ss, z, al);
        n_checks++;
        if (dut_view() !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, dut_view(), want);
        end
    endtask

    // Monitor: one expected display per clock edge, sampled just after the edge.
    always @(posedge clk) begin
        logic [17:0] want;
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got %h required queued entry", dut_view());
        end else begin
            want = exp_q.pop_front();
            if (dut_view() !== want) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got %h required %h", $time, dut_view(), want);
            end
        end
    end

    initial begin
        int len;
        bit en, fwd;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_time("reset_state", 0, 0, 1'b1, 1'b0);
        idle(1'b0, 1'b0, 1);

        repeat (3) seg_pulse();
        repeat (2) min_pulse();
        check_time("edit_0203", 2, 3, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1);
        check_time("held_demand", 2, 4, 1'b0, 1'b0);
        repeat (55) seg_pulse();
        check_time("sec_59", 2, 59, 1'b0, 1'b0);
        seg_pulse();
        check_time("sec_wrap", 2, 0, 1'b0, 1'b0);
        repeat (97) min_pulse();
        check_time("min_99", 99, 0, 1'b0, 1'b0);
        min_pulse();
        check_time("min_wrap", 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 1);
        check_time("both_edges", 1, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 2);
        check_time("ignored_outside_edit", 1, 1, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        min_pulse();
        idle(1'b1, 1'b0, 3);
        check_time("before_first_tick", 1, 0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1);
        check_time("first_tick", 0, 59, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 59 * TPS);
        check_time("expired", 0, 0, 1'b1, ALARM_ON);
        idle(1'b1, 1'b0, 3 * TPS);
        check_time("hold_at_zero", 0, 0, 1'b1, ALARM_ON);
        seg_pulse();
        check_time("edit_clears_alarm", 0, 1, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) seg_pulse();
        idle(1'b1, 1'b0, 2);
        idle(1'b0, 1'b0, 10);
        check_time("frozen", 0, 5, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 3);
        check_time("restart_full", 0, 5, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1);
        check_time("resume_tick", 0, 4, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) min_pulse();
        repeat (17) seg_pulse();
        idle(1'b1, 1'b0, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_time("reset_timer", 0, 0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        seg_pulse();
        idle(1'b1, 1'b0, 3);
        check_time("presc_restart", 0, 1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1);
        check_time("presc_restart_tick", 0, 0, 1'b1, ALARM_ON);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (150) begin
            len = $urandom_range(1, 30);
            en  = ($urandom_range(0, 9) != 0);
            fwd = $urandom_range(0, 1) == 1;
            repeat (len) begin
                step($urandom_range(0, 299) == 0, en, fwd, $urandom_range(0, 149) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            end
        end

        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clk cycles per one-second tick.
REQ-002 The block SHALL have parameter MIN_MAX, default 99, meaning the highest minute value (1..99).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enableCounter  input  1  count/edit enable from the timer control FSM.
REQ-006 forward  input  1  1 = setting (edit) mode, 0 = countdown mode.
REQ-007 resetTimer  input  1  clear request from the timer control FSM (level).
REQ-008 segDemand  input  1  seconds-increment request (level, rising-edge detected internally).
REQ-009 minDemand  input  1  minutes-increment request (level, rising-edge detected internally).
REQ-010 secUnits, secTens, minUnits, minTens  output  4 each  BCD digits of the current time, registered.
REQ-011 zero  output  1  registered; 1 when the time is 00:00.
REQ-012 alarm  output  1  registered expiry flag (see Configuration).

Function
REQ-013 Internal state SHALL be binary seconds (6 bits, 0..59), minutes (7 bits, 0..MIN_MAX), a prescaler counter and one delay flop each for segDemand and minDemand.
REQ-014 BCD outputs SHALL be derived from the binary registers and SHALL update in the same cycle the binary value is registered (no extra latency).
REQ-015 Priority per cycle SHALL be: reset > resetTimer > edit (enableCounter=1, forward=1) > countdown (enableCounter=1, forward=0) > hold.
REQ-016 resetTimer=1 SHALL clear seconds, minutes and prescaler to 0 on the next edge; it holds the value at 00:00 while asserted.
REQ-017 Edit mode: each rising edge of segDemand SHALL increment seconds by 1, wrapping 59->0 without carry into minutes.
REQ-018 Edit mode: each rising edge of minDemand SHALL increment minutes by 1, wrapping MIN_MAX->0.
REQ-019 Simultaneous segDemand and minDemand rising edges in the same cycle SHALL apply both increments.
REQ-020 A held-high demand input SHALL produce exactly one increment; demand edges outside edit mode SHALL be ignored, but edge-detector flops SHALL track inputs every cycle.
REQ-021 Prescaler SHALL be held at 0 whenever not in countdown mode; in countdown mode it SHALL count 0..TICKS_PER_SEC-1 and issue a one-cycle tick when it wraps.
REQ-022 First decrement SHALL occur exactly TICKS_PER_SEC cycles after countdown mode begins.
REQ-023 On tick: if seconds>0, seconds-1; else if minutes>0, seconds=59 and minutes-1; else hold at 00:00 (no wrap-around).
REQ-024 Dropping enableCounter mid-count (stop) SHALL freeze time; resuming SHALL restart the full TICKS_PER_SEC interval.
REQ-025 zero SHALL reflect the registered time in the same cycle it changes.

Reset
REQ-026 reset=1 SHALL on the next rising clk edge set seconds, minutes, prescaler, edge-detect flops to 0, secUnits/secTens/minUnits/minTens to 0, zero to 1 and alarm to 0.
REQ-027 reset asserted mid-count or mid-edit SHALL abort the operation with no pending increment or tick surviving.

Configuration
REQ-028 With macro TIMER_ALARM_EN defined, alarm SHALL set in the cycle the time reaches 00:00 via a countdown tick, and clear on reset, resetTimer or any applied edit increment.
REQ-029 Without TIMER_ALARM_EN, alarm SHALL be constant 0 and no alarm logic SHALL be synthesised.

Verification (TICKS_PER_SEC=4, MIN_MAX=99)
REQ-030 reset 1 cycle -> all digits 0, zero=1, alarm=0.
REQ-031 Edit mode, 3 segDemand pulses, 2 minDemand pulses -> display 02:03, zero=0; segDemand held 10 cycles -> one increment only.
REQ-032 Edit, seconds at 59, one segDemand -> 02:00 (no carry); minutes at 99, one minDemand -> 00:xx.
REQ-033 Load 01:00, countdown mode -> 00:59 exactly 4 cycles after entry; continues to 00:00, then holds; zero=1; alarm=1 only with TIMER_ALARM_EN.
REQ-034 Countdown at 00:05, enableCounter low 10 cycles -> value frozen at 00:05; re-enable -> 00:04 after 4 cycles.
REQ-035 resetTimer=1 during countdown at 03:17 -> 00:00 next cycle, alarm=0, prescaler restarted.
